// File: rtl/mm_match_ctrl.sv
// mm_match_ctrl
//   Matching-control stage that sits directly in front of the matching memory.
//   Each token is hashed from {color/gen, dest} to a table address. The stage
//   keeps a valid/tag/LR entry per address and decides what the token does:
//     - pass through to the constant read (MF=0),
//     - be stored and deleted downstream (WR_E=1, DEL=1),
//     - fire with its stored partner (WR_E=0, DEL=0).
//   A token whose address is held by a different tag is parked in a small
//   retry FIFO and evaluated again later.
// Ports
//   CP          clock, rising edge
//   MR_n        synchronous active-low master reset
//   Send_in     upstream token valid
//   PACKET_IN   upstream token
//   Ack_out     upstream ready (token taken on Send_in & Ack_out)
//   Send_out    output beat valid
//   Ack_in      downstream ready (beat taken on Send_out & Ack_in)
//   PACKET_OUT  forwarded token
//   ADDR        matching-memory address of the beat
//   WR_E        store token at ADDR
//   DEL         delete after write (no fire)
//   occ_cnt     number of valid table entries
//   err_dup     sticky: duplicate same-tag, same-LR token seen
module mm_match_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int RQ_DEPTH = 4,
    parameter int PKT_W    = 38
) (
    input  logic              CP,
    input  logic              MR_n,
    input  logic              Send_in,
    input  logic [PKT_W-1:0]  PACKET_IN,
    output logic              Ack_out,
    output logic              Send_out,
    input  logic              Ack_in,
    output logic [PKT_W-1:0]  PACKET_OUT,
    output logic [ADDR_W-1:0] ADDR,
    output logic              WR_E,
    output logic              DEL,
    output logic [ADDR_W:0]   occ_cnt,
    output logic              err_dup
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int RQ_AW = $clog2(RQ_DEPTH);
    localparam int RQ_CW = RQ_AW + 1;
    localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(RQ_DEPTH);

    // match table
    logic [DEPTH-1:0] tv_q;
    logic [DEPTH-1:0] lr_q;
    logic [17:0]      tag_q [DEPTH];

    // retry FIFO
    logic [PKT_W-1:0] rq_mem_q [RQ_DEPTH];
    logic [RQ_AW-1:0] rq_rd_q, rq_wr_q;
    logic [RQ_CW-1:0] rq_cnt_q;

    // output register
    logic              ov_q;
    logic [PKT_W-1:0]  pkt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q, del_q;
    logic [ADDR_W:0]   occ_q;
    logic              err_q;

    logic              rq_empty, rq_full, slot, sel_retry, tok_vld;
    logic [PKT_W-1:0]  tok;
    logic [ADDR_W-1:0] idx;
    logic [17:0]       tag;
    logic              beat, beat_wr, beat_del, tbl_set, tbl_clr, dup, park, pop;

    assign rq_empty  = (rq_cnt_q == '0);
    assign rq_full   = (rq_cnt_q == RQ_FULL);
    assign slot      = !ov_q || Ack_in;
    // Retry head wins when the input is idle, or when the FIFO is full and
    // the input cannot be parked anyway.
    assign sel_retry = !rq_empty && (!Send_in || rq_full);
    assign Ack_out   = MR_n && slot && !sel_retry && !rq_full;

    assign tok     = sel_retry ? rq_mem_q[rq_rd_q] : PACKET_IN;
    assign tok_vld = sel_retry ? slot : (Send_in && Ack_out);
    assign idx     = ADDR_W'(tok[26:20] ^ tok[33:27] ^ {3'b000, tok[37:34]});
    assign tag     = tok[37:20];
    assign pop     = tok_vld && sel_retry;

    always_comb begin
        beat     = 1'b0;
        beat_wr  = 1'b0;
        beat_del = 1'b0;
        tbl_set  = 1'b0;
        tbl_clr  = 1'b0;
        dup      = 1'b0;
        park     = 1'b0;
        if (tok_vld) begin
            if (!tok[18]) begin
                beat = 1'b1;
            end else if (!tv_q[idx]) begin
                beat     = 1'b1;
                beat_wr  = 1'b1;
                beat_del = 1'b1;
                tbl_set  = 1'b1;
            end else if (tag_q[idx] == tag) begin
                if (lr_q[idx] != tok[19]) begin
                    beat    = 1'b1;
                    tbl_clr = 1'b1;
                end else begin
                    dup = 1'b1;
                end
            end else begin
                // A parked retry head is popped and re-pushed: rotation.
                park = 1'b1;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (!MR_n) begin
            tv_q     <= '0;
            rq_rd_q  <= '0;
            rq_wr_q  <= '0;
            rq_cnt_q <= '0;
            ov_q     <= 1'b0;
            pkt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            del_q    <= 1'b0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (tbl_set) begin
                tv_q[idx] <= 1'b1;
                occ_q     <= occ_q + 1'b1;
            end else if (tbl_clr) begin
                tv_q[idx] <= 1'b0;
                occ_q     <= occ_q - 1'b1;
            end
            if (dup) err_q <= 1'b1;

            if (pop)  rq_rd_q <= rq_rd_q + 1'b1;
            if (park) rq_wr_q <= rq_wr_q + 1'b1;
            if (park && !pop)      rq_cnt_q <= rq_cnt_q + 1'b1;
            else if (pop && !park) rq_cnt_q <= rq_cnt_q - 1'b1;

            if (slot) begin
                ov_q <= beat;
                if (beat) begin
                    pkt_q  <= tok;
                    addr_q <= idx;
                    wr_q   <= beat_wr;
                    del_q  <= beat_del;
                end
            end
        end
    end

    // Payload storage needs no reset: entries are qualified by tv_q / rq_cnt_q.
    always_ff @(posedge CP) begin
        if (tbl_set) begin
            tag_q[idx] <= tag;
            lr_q[idx]  <= tok[19];
        end
        if (park) rq_mem_q[rq_wr_q] <= tok;
    end

    assign Send_out   = ov_q;
    assign PACKET_OUT = pkt_q;
    assign ADDR       = addr_q;
    assign WR_E       = wr_q;
    assign DEL        = del_q;
    assign occ_cnt    = occ_q;
    assign err_dup    = err_q;
endmodule

// File: tb/tb_mm_match_ctrl.sv
// Directed bench for mm_match_ctrl with a queue-based reference model
// checked every cycle, plus hand-computed literal checks.
module tb_mm_match_ctrl;
    localparam int AW  = 6;
    localparam int RQD = 4;
    localparam int PW  = 38;

    logic          CP = 1'b0, MR_n = 1'b0, Send_in = 1'b0, Ack_in = 1'b0;
    logic [PW-1:0] PACKET_IN = '0;
    logic          Ack_out, Send_out, WR_E, DEL, err_dup;
    logic [PW-1:0] PACKET_OUT;
    logic [AW-1:0] ADDR;
    logic [AW:0]   occ_cnt;

    mm_match_ctrl #(.ADDR_W(AW), .RQ_DEPTH(RQD), .PKT_W(PW)) dut (
        .CP(CP), .MR_n(MR_n), .Send_in(Send_in), .PACKET_IN(PACKET_IN),
        .Ack_out(Ack_out), .Send_out(Send_out), .Ack_in(Ack_in),
        .PACKET_OUT(PACKET_OUT), .ADDR(ADDR), .WR_E(WR_E), .DEL(DEL),
        .occ_cnt(occ_cnt), .err_dup(err_dup)
    );

    always #5 CP = ~CP;

    int total = 0, bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mk(input int cg, input int d, input bit lr,
                                         input bit mf, input int data);
        return {cg[10:0], d[6:0], lr, mf, 2'b00, data[15:0]};
    endfunction

    // ---------------- reference model ----------------
    bit            m_tv  [64];
    logic [17:0]   m_tag [64];
    bit            m_lr  [64];
    logic [PW-1:0] m_rq [$];
    bit            m_ov, m_wr, m_del, m_err;
    logic [PW-1:0] m_pkt;
    int            m_addr, m_occ;

    function automatic int hsh(input logic [PW-1:0] t);
        int cg, d;
        cg = int'(t[37:27]);
        d  = int'(t[26:20]);
        return (d ^ (cg % 128) ^ (cg / 128)) % 64;
    endfunction

    function automatic bit exp_ack();
        bit slot, selr;
        slot = !m_ov || Ack_in;
        selr = (m_rq.size() != 0) && (!Send_in || m_rq.size() == RQD);
        return MR_n && slot && !selr && (m_rq.size() < RQD);
    endfunction

    task automatic m_beat(input logic [PW-1:0] t, input int a, input bit wr, input bit del);
        m_ov = 1'b1; m_pkt = t; m_addr = a; m_wr = wr; m_del = del;
    endtask

    task automatic m_decide(input logic [PW-1:0] t);
        int a;
        a = hsh(t);
        if (!t[18]) m_beat(t, a, 1'b0, 1'b0);
        else if (!m_tv[a]) begin
            m_tv[a] = 1'b1; m_tag[a] = t[37:20]; m_lr[a] = t[19]; m_occ++;
            m_beat(t, a, 1'b1, 1'b1);
        end else if (m_tag[a] == t[37:20]) begin
            if (m_lr[a] != t[19]) begin
                m_tv[a] = 1'b0; m_occ--;
                m_beat(t, a, 1'b0, 1'b0);
            end else m_err = 1'b1;
        end else m_rq.push_back(t);
    endtask

    always @(posedge CP) begin
        bit slot, selr, ack;
        logic [PW-1:0] t;
        if (!MR_n) begin
            foreach (m_tv[i]) m_tv[i] = 1'b0;
            m_rq.delete();
            m_ov = 1'b0; m_occ = 0; m_err = 1'b0;
        end else begin
            slot = !m_ov || Ack_in;
            selr = (m_rq.size() != 0) && (!Send_in || m_rq.size() == RQD);
            ack  = slot && !selr && (m_rq.size() < RQD);
            if (slot) m_ov = 1'b0;
            if (slot && selr) begin
                t = m_rq.pop_front();
                m_decide(t);
            end else if (Send_in && ack) m_decide(PACKET_IN);
        end
    end

    always @(negedge CP) begin
        if (chk_en) begin
            chk("Send_out", Send_out, m_ov);
            chk("Ack_out", Ack_out, exp_ack());
            chk("occ_cnt", occ_cnt, m_occ);
            chk("err_dup", err_dup, m_err);
            if (m_ov) begin
                chk("PACKET_OUT", PACKET_OUT, m_pkt);
                chk("ADDR", ADDR, m_addr);
                chk("WR_E", WR_E, m_wr);
                chk("DEL", DEL, m_del);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit s, input logic [PW-1:0] p, input bit a);
        Send_in = s; PACKET_IN = p; Ack_in = a;
        @(posedge CP); #1;
    endtask

    logic [PW-1:0] tA, L, R, A, B, Ap, Bp, t0, t1, t2, D, S, X;

    initial begin
        // T1 reset
        MR_n = 1'b0;
        drv(0, '0, 1); drv(0, '0, 1);
        chk_en = 1'b1;
        chk("rst Send_out", Send_out, 0); chk("rst ADDR", ADDR, 0);
        chk("rst WR_E", WR_E, 0);         chk("rst DEL", DEL, 0);
        chk("rst PACKET_OUT", PACKET_OUT, 0);
        chk("rst occ_cnt", occ_cnt, 0);   chk("rst err_dup", err_dup, 0);
        chk("rst Ack_out", Ack_out, 0);
        MR_n = 1'b1; #1;
        chk("rel Ack_out", Ack_out, 1);
        drv(0, '0, 1);

        // T2 constant path
        tA = mk(0, 5, 0, 0, 16'h1234);
        drv(1, tA, 1);
        chk("T2 Send_out", Send_out, 1); chk("T2 ADDR", ADDR, 5);
        chk("T2 WR_E", WR_E, 0); chk("T2 DEL", DEL, 0); chk("T2 pkt", PACKET_OUT, tA);
        drv(0, '0, 1);

        // T3 pair at addr 3^9=10
        L = mk(3, 9, 0, 1, 16'hAAAA); R = mk(3, 9, 1, 1, 16'h5555);
        drv(1, L, 1);
        chk("T3 L ADDR", ADDR, 10); chk("T3 L WR_E", WR_E, 1);
        chk("T3 L DEL", DEL, 1);    chk("T3 L occ", occ_cnt, 1);
        drv(1, R, 1);
        chk("T3 R ADDR", ADDR, 10); chk("T3 R WR_E", WR_E, 0);
        chk("T3 R DEL", DEL, 0);    chk("T3 R occ", occ_cnt, 0);
        chk("T3 R pkt", PACKET_OUT, R);
        drv(0, '0, 1);
        chk("T3 idle", Send_out, 0);

        // T4 collision at addr 1
        A = mk(0, 1, 0, 1, 1); B = mk(1, 0, 0, 1, 2);
        Ap = mk(0, 1, 1, 1, 3); Bp = mk(1, 0, 1, 1, 4);
        drv(1, A, 1);
        chk("T4 A ADDR", ADDR, 1); chk("T4 A WR_E", WR_E, 1);
        drv(1, B, 1);
        chk("T4 B nobeat", Send_out, 0); chk("T4 B occ", occ_cnt, 1);
        drv(1, Ap, 1);
        chk("T4 fire", Send_out, 1); chk("T4 fire WR_E", WR_E, 0);
        chk("T4 fire ADDR", ADDR, 1); chk("T4 fire occ", occ_cnt, 0);
        drv(0, '0, 1);
        chk("T4 retry", Send_out, 1); chk("T4 retry pkt", PACKET_OUT, B);
        chk("T4 retry WR_E", WR_E, 1); chk("T4 retry DEL", DEL, 1);
        chk("T4 retry occ", occ_cnt, 1);
        drv(1, Bp, 1);
        chk("T4 Bp occ", occ_cnt, 0);
        drv(0, '0, 1);

        // T5 backpressure
        t0 = mk(0, 10, 0, 0, 10); t1 = mk(0, 11, 0, 0, 11); t2 = mk(0, 12, 0, 0, 12);
        drv(1, t0, 0);
        chk("T5 t0", PACKET_OUT, t0);
        for (int i = 0; i < 4; i++) begin
            drv(1, t1, 0);
            chk("T5 hold pkt", PACKET_OUT, t0); chk("T5 hold vld", Send_out, 1);
            chk("T5 hold ack", Ack_out, 0);
        end
        drv(1, t1, 1);
        chk("T5 t1", PACKET_OUT, t1);
        drv(1, t2, 1);
        chk("T5 t2", PACKET_OUT, t2);
        drv(0, '0, 1);
        chk("T5 drain", Send_out, 0);

        // T6 duplicate
        D = mk(7, 20, 0, 1, 7);
        drv(1, D, 1); drv(1, D, 1);
        chk("T6 nobeat", Send_out, 0); chk("T6 err", err_dup, 1); chk("T6 occ", occ_cnt, 1);
        drv(0, '0, 1);
        chk("T6 sticky", err_dup, 1);

        // FIFO fill: four tokens colliding at addr 2, fifth stalls
        S = mk(0, 2, 0, 1, 0);
        drv(1, S, 1);
        chk("F store occ", occ_cnt, 2);
        for (int k = 1; k <= 4; k++) begin
            drv(1, mk(k, 2 ^ k, 0, 1, k), 1);
            chk("F park nobeat", Send_out, 0);
        end
        X = mk(5, 7, 0, 1, 5);
        for (int i = 0; i < 3; i++) begin
            drv(1, X, 1);
            chk("F full ack", Ack_out, 0);
        end
        for (int i = 0; i < 4; i++) drv(0, '0, 1);

        // reset mid-operation
        MR_n = 1'b0;
        drv(0, '0, 1);
        chk("R2 Send_out", Send_out, 0); chk("R2 occ", occ_cnt, 0);
        chk("R2 err", err_dup, 0);       chk("R2 ack", Ack_out, 0);
        MR_n = 1'b1;
        drv(0, '0, 1); drv(0, '0, 1);
        chk("R2 rel ack", Ack_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
